// File: rtl/led_blink_scheduler.sv
// LED bank mode controller: one prescaler sequenced through off / 1 Hz / 4 Hz / chase modes.
// Optional auto-advance between blinking modes is enabled by defining LED_SCHED_AUTO_EN.
module led_blink_scheduler #(
  parameter int SEC_TICKS    = 100000000,
  parameter int NUM_LED      = 16,
  parameter int AUTO_PERIODS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_next,
  input  logic               btn_pause,
  output logic [NUM_LED-1:0] LED,
  output logic [1:0]         mode,
  output logic               tick,
  output logic               paused
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLOW  = 2'd1,
    FAST  = 2'd2,
    CHASE = 2'd3
  } mode_e;

  localparam logic [31:0] TERM_SLOW  = 32'(SEC_TICKS - 1);
  localparam logic [31:0] TERM_FAST  = 32'(SEC_TICKS / 4 - 1);
  localparam logic [31:0] TERM_CHASE = 32'(SEC_TICKS / 8 - 1);

  if ((SEC_TICKS < 8) || (SEC_TICKS % 8 != 0) || (NUM_LED < 2) || (AUTO_PERIODS < 1)) begin : g_bad_param
    $error("led_blink_scheduler: illegal parameter combination");
  end

  mode_e              mode_q, mode_d;
  logic [NUM_LED-1:0] led_q, led_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic               paused_q, paused_d;
  logic [31:0]        term;
  logic               adv;
  logic               auto_adv;
  logic               step_evt;

  function automatic mode_e next_mode_btn(input mode_e m);
    case (m)
      IDLE:    return SLOW;
      SLOW:    return FAST;
      FAST:    return CHASE;
      default: return IDLE;
    endcase
  endfunction

  // Auto-advance cycles only through the blinking modes, never into or out of IDLE.
  function automatic mode_e next_mode_auto(input mode_e m);
    case (m)
      SLOW:    return FAST;
      FAST:    return CHASE;
      CHASE:   return SLOW;
      default: return IDLE;
    endcase
  endfunction

  function automatic logic [NUM_LED-1:0] entry_led(input mode_e m);
    return (m == CHASE) ? NUM_LED'(1) : '0;
  endfunction

  function automatic logic [NUM_LED-1:0] step_led(input mode_e m, input logic [NUM_LED-1:0] cur);
    return (m == CHASE) ? {cur[NUM_LED-2:0], cur[NUM_LED-1]} : ~cur;
  endfunction

  always_comb begin
    case (mode_q)
      SLOW:    term = TERM_SLOW;
      FAST:    term = TERM_FAST;
      CHASE:   term = TERM_CHASE;
      default: term = '0;
    endcase
  end

  // A mode change preempts pause toggling and any step landing in the same cycle.
  always_comb begin
    mode_d   = mode_q;
    led_d    = led_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    paused_d = paused_q;
    step_evt = 1'b0;
    adv      = btn_next | auto_adv;
    if (adv) begin
      mode_d   = btn_next ? next_mode_btn(mode_q) : next_mode_auto(mode_q);
      cnt_d    = '0;
      paused_d = 1'b0;
      led_d    = entry_led(mode_d);
    end else if (mode_q == IDLE) begin
      cnt_d    = '0;
      led_d    = '0;
      paused_d = 1'b0;
    end else begin
      if (btn_pause) paused_d = ~paused_q;
      if (!paused_d) begin
        if (cnt_q == term) begin
          cnt_d    = '0;
          led_d    = step_led(mode_q, led_q);
          tick_d   = 1'b1;
          step_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= IDLE;
      led_q    <= '0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      led_q    <= led_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      paused_q <= paused_d;
    end
  end

`ifdef LED_SCHED_AUTO_EN
  localparam int AUTO_W = $clog2(AUTO_PERIODS + 1);

  logic [AUTO_W-1:0] step_q, step_d;

  assign auto_adv = (mode_q != IDLE) && (step_q == AUTO_W'(AUTO_PERIODS));

  always_comb begin
    step_d = step_q;
    if (adv)           step_d = '0;
    else if (step_evt) step_d = step_q + AUTO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) step_q <= '0;
    else     step_q <= step_d;
  end
`else
  assign auto_adv = 1'b0;
`endif

  assign LED    = led_q;
  assign mode   = mode_q;
  assign tick   = tick_q;
  assign paused = paused_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Bench for led_blink_scheduler with SEC_TICKS=16 (terms SLOW 15, FAST 3, CHASE 1).
module tb_led_blink_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_next = 1'b0;
  logic        btn_pause = 1'b0;
  logic [15:0] LED;
  logic [1:0]  mode;
  logic        tick;
  logic        paused;

  always #5 clk = ~clk;

  led_blink_scheduler #(
    .SEC_TICKS   (16),
    .NUM_LED     (16),
    .AUTO_PERIODS(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_next (btn_next),
    .btn_pause(btn_pause),
    .LED      (LED),
    .mode     (mode),
    .tick     (tick),
    .paused   (paused)
  );

  typedef struct {
    logic [15:0] led;
    logic [1:0]  mode;
    logic        tick;
    logic        paused;
    int          tag;
  } exp_t;

  typedef struct {
    logic        n;
    logic        p;
    logic        r;
    logic [15:0] led;
    logic [1:0]  mode;
    logic        tick;
    logic        paused;
  } vec_t;

  exp_t sb[$];
  exp_t cur_e;
  int   checks = 0;
  int   errors = 0;
  int   tag    = 0;

  // Outputs registered at posedge; expectation pushed at the preceding negedge.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      cur_e = sb.pop_front();
      checks++;
      if ({LED, mode, tick, paused} !== {cur_e.led, cur_e.mode, cur_e.tick, cur_e.paused}) begin
        errors++;
        $display("FAIL chk%0d: got led=%h mode=%0d tick=%b paused=%b, expected led=%h mode=%0d tick=%b paused=%b",
                 cur_e.tag, LED, mode, tick, paused, cur_e.led, cur_e.mode, cur_e.tick, cur_e.paused);
      end
    end
  end

  task automatic drive(input logic n, input logic p, input logic r,
                       input logic [15:0] el, input logic [1:0] em, input logic et, input logic ep);
    exp_t e;
    @(negedge clk);
    btn_next  = n;
    btn_pause = p;
    rst       = r;
    e.led = el; e.mode = em; e.tick = et; e.paused = ep; e.tag = tag;
    sb.push_back(e);
    tag++;
  endtask

  function automatic logic [15:0] rotl(input logic [15:0] v);
    return {v[14:0], v[15]};
  endfunction

  vec_t        vecs[16];
  logic [15:0] cur;

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0001, 2'd3, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'h0001, 2'd3, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0002, 2'd3, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0002, 2'd3, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h0002, 2'd3, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0002, 2'd3, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h0004, 2'd3, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 16'h0000, 2'd0, 1'b0, 1'b0};

    for (int i = 0; i < 16; i++)
      drive(vecs[i].n, vecs[i].p, vecs[i].r, vecs[i].led, vecs[i].mode, vecs[i].tick, vecs[i].paused);

    // SLOW: toggle every 16 cycles.
    drive(1'b0, 1'b0, 1'b1, 16'h0000, 2'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b0);
    cur = 16'h0000;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 15; i++) drive(1'b0, 1'b0, 1'b0, cur, 2'd1, 1'b0, 1'b0);
      cur = ~cur;
      drive(1'b0, 1'b0, 1'b0, cur, 2'd1, 1'b1, 1'b0);
    end
`ifdef LED_SCHED_AUTO_EN
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b0);
`else
    for (int i = 0; i < 15; i++) drive(1'b0, 1'b0, 1'b0, cur, 2'd1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, ~cur, 2'd1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, ~cur, 2'd1, 1'b0, 1'b0);
`endif

    // FAST: pause at cnt=2, hold 20 cycles, resume steps 2 cycles later.
    drive(1'b0, 1'b0, 1'b1, 16'h0000, 2'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'hFFFF, 2'd2, 1'b1, 1'b0);

    // Paused in SLOW, next+pause together: FAST with a fresh period.
    drive(1'b0, 1'b0, 1'b1, 16'h0000, 2'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'hFFFF, 2'd2, 1'b1, 1'b0);

    // btn_next on the FAST terminal cycle: enter CHASE without stepping.
    drive(1'b0, 1'b0, 1'b1, 16'h0000, 2'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h0001, 2'd3, 1'b0, 1'b0);
    cur = 16'h0001;
`ifdef LED_SCHED_AUTO_EN
    for (int s = 0; s < 2; s++) begin
      drive(1'b0, 1'b0, 1'b0, cur, 2'd3, 1'b0, 1'b0);
      cur = rotl(cur);
      drive(1'b0, 1'b0, 1'b0, cur, 2'd3, 1'b1, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b0);
`else
    for (int s = 0; s < 16; s++) begin
      drive(1'b0, 1'b0, 1'b0, cur, 2'd3, 1'b0, 1'b0);
      cur = rotl(cur);
      drive(1'b0, 1'b0, 1'b0, cur, 2'd3, 1'b1, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0001, 2'd3, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0);
`endif

    @(negedge clk);
    btn_next  = 1'b0;
    btn_pause = 1'b0;
    rst       = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
